// File: rtl/sender_pkg.sv
// Shared definitions for the wireless sender: scheduler state encoding,
// clock period and default datapath widths.
package sender_pkg;

  localparam int CLK_PERIOD_NS = 20;
  localparam int DEF_COUNT_W   = 8;
  localparam int DEF_GAP_W     = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    FIRE = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/burst_gap_timer.sv
// Loadable down-counter with a zero flag; times both the inter-pulse gap
// and the FIRE watchdog, since the two never run at the same time.
module burst_gap_timer #(
  parameter int GAP_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [GAP_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/impulse_burst_scheduler.sv
// Drives the single-impulse generator through bursts of N impulses with a
// programmable gap, and flags each impulse and burst completion to the meter.
module impulse_burst_scheduler
  import sender_pkg::*;
#(
  parameter int COUNT_W        = DEF_COUNT_W,
  parameter int GAP_W          = DEF_GAP_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_Start,
  input  logic               i_Abort,
  input  logic [COUNT_W-1:0] i_Burst_Len,
  input  logic [GAP_W-1:0]   i_Gap_Cycles,
  output logic               o_Gen_Arm,
  output logic               o_Gen_Enable,
  input  logic               i_Gen_Ready,
  output logic               o_Pulse_Strobe,
  output logic [COUNT_W-1:0] o_Pulse_Idx,
  output logic               o_Busy,
  output logic               o_Done,
  output logic               o_Timeout
);

  // Loaded on FIRE entry so the timer reaches zero in the last allowed cycle.
  localparam logic [GAP_W-1:0] TMO_LOAD = GAP_W'(TIMEOUT_CYCLES - 1);

  state_t             state_reg, state_next;
  logic [COUNT_W-1:0] len_reg, len_next;
  logic [GAP_W-1:0]   gap_reg, gap_next;
  logic [COUNT_W-1:0] idx_reg, idx_next;
  logic               timeout_reg, timeout_next;
  logic               arm_reg, enable_reg, busy_reg, done_reg;

  logic               tmr_load;
  logic [GAP_W-1:0]   tmr_load_val;
  logic               tmr_dec;
  logic               tmr_zero;

  burst_gap_timer #(
    .GAP_W(GAP_W)
  ) u_timer (
    .clk      (i_Clk),
    .rst_n    (i_Rst_L),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_reg   <= IDLE;
      len_reg     <= '0;
      gap_reg     <= '0;
      idx_reg     <= '0;
      timeout_reg <= 1'b0;
      arm_reg     <= 1'b0;
      enable_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      len_reg     <= len_next;
      gap_reg     <= gap_next;
      idx_reg     <= idx_next;
      timeout_reg <= timeout_next;
      // Outputs decode the upcoming state so they are registered yet aligned.
      arm_reg     <= (state_next == ARM);
      enable_reg  <= (state_next == FIRE);
      busy_reg    <= (state_next != IDLE);
      done_reg    <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    gap_next     = gap_reg;
    idx_next     = idx_reg;
    timeout_next = timeout_reg;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (i_Start && !i_Abort) begin
          len_next     = i_Burst_Len;
          gap_next     = i_Gap_Cycles;
          idx_next     = '0;
          timeout_next = 1'b0;
          state_next   = (i_Burst_Len == '0) ? DONE : ARM;
        end
      end
      ARM: begin
        state_next   = FIRE;
        tmr_load     = 1'b1;
        tmr_load_val = TMO_LOAD;
      end
      FIRE: begin
        // A ready in the watchdog's final cycle still counts as a pulse.
        if (i_Gen_Ready) begin
          idx_next = idx_reg + 1'b1;
          if (idx_next == len_reg) begin
            state_next = DONE;
          end else if (gap_reg != '0) begin
            state_next   = GAP;
            tmr_load     = 1'b1;
            tmr_load_val = gap_reg - 1'b1;
          end else begin
            state_next = ARM;
          end
        end else if (tmr_zero) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      GAP: begin
        if (tmr_zero) begin
          state_next = ARM;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort overrides everything, including a ready arriving in the same cycle.
    if ((state_reg != IDLE) && i_Abort) begin
      state_next   = IDLE;
      idx_next     = idx_reg;
      timeout_next = timeout_reg;
      tmr_load     = 1'b0;
      tmr_dec      = 1'b0;
    end
  end

  assign o_Gen_Arm      = arm_reg;
  assign o_Pulse_Strobe = arm_reg;
  assign o_Gen_Enable   = enable_reg;
  assign o_Busy         = busy_reg;
  assign o_Done         = done_reg;
  assign o_Pulse_Idx    = idx_reg;
  assign o_Timeout      = timeout_reg;

endmodule

// File: tb/tb_impulse_burst_scheduler.sv
// Directed bench: each scenario is expanded into an expected per-cycle
// timeline from the burst timing rules, then checked cycle by cycle.
module tb_impulse_burst_scheduler;
  import sender_pkg::*;

  localparam int CW   = 8;
  localparam int GW   = 16;
  localparam int TMO  = 255;
  localparam int MAXC = 320;

  logic          i_Clk = 1'b0;
  logic          i_Rst_L = 1'b1;
  logic          i_Start = 1'b0;
  logic          i_Abort = 1'b0;
  logic [CW-1:0] i_Burst_Len = '0;
  logic [GW-1:0] i_Gap_Cycles = '0;
  logic          i_Gen_Ready = 1'b0;
  logic          o_Gen_Arm, o_Gen_Enable, o_Pulse_Strobe, o_Busy, o_Done, o_Timeout;
  logic [CW-1:0] o_Pulse_Idx;

  impulse_burst_scheduler #(
    .COUNT_W(CW), .GAP_W(GW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Rst_L        (i_Rst_L),
    .i_Start        (i_Start),
    .i_Abort        (i_Abort),
    .i_Burst_Len    (i_Burst_Len),
    .i_Gap_Cycles   (i_Gap_Cycles),
    .o_Gen_Arm      (o_Gen_Arm),
    .o_Gen_Enable   (o_Gen_Enable),
    .i_Gen_Ready    (i_Gen_Ready),
    .o_Pulse_Strobe (o_Pulse_Strobe),
    .o_Pulse_Idx    (o_Pulse_Idx),
    .o_Busy         (o_Busy),
    .o_Done         (o_Done),
    .o_Timeout      (o_Timeout)
  );

  always #(CLK_PERIOD_NS / 2) i_Clk = ~i_Clk;

  // Expected outputs and stimulus, indexed by cycle within a scenario.
  int e_arm[MAXC], e_en[MAXC], e_busy[MAXC], e_done[MAXC], e_tmo[MAXC], e_idx[MAXC];
  int s_start[MAXC], s_abort[MAXC], s_ready[MAXC];

  int checks = 0, failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int idx_carry = 0, tmo_carry = 0;
  logic [CW-1:0] cfg_len;
  logic [GW-1:0] cfg_gap;

  int stb_q[$];
  int done_at, tmo_at, arm_cnt, en_cnt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  // Start at cycle 0; pulse k strobes at s_k, ready comes R cycles after the
  // enable rises, then G gap cycles precede the next strobe.
  task automatic build(input int L, input int G, input int R, input int abort_at,
                       input bit no_ready, input bit blocked, input int extra_start);
    int s, r;
    for (int c = 0; c < MAXC; c++) begin
      e_arm[c] = 0; e_en[c] = 0; e_busy[c] = 0; e_done[c] = 0;
      e_idx[c] = idx_carry; e_tmo[c] = tmo_carry;
      s_start[c] = 0; s_abort[c] = 0; s_ready[c] = 0;
    end
    s_start[0] = 1;
    if (blocked) begin
      s_abort[0] = 1;
      return;
    end
    for (int c = 1; c < MAXC; c++) begin
      e_tmo[c] = 0;
      e_idx[c] = 0;
    end
    if (L == 0) begin
      e_done[1] = 1;
      e_busy[1] = 1;
      return;
    end
    s = 1;
    for (int k = 0; k < L; k++) begin
      e_arm[s] = 1;
      for (int c = s; c < MAXC; c++) e_idx[c] = k;
      if (no_ready) begin
        for (int c = s; c <= s + TMO && c < MAXC; c++) e_busy[c] = 1;
        for (int c = s + 1; c <= s + TMO && c < MAXC; c++) e_en[c] = 1;
        for (int c = s + TMO + 1; c < MAXC; c++) e_tmo[c] = 1;
        break;
      end
      r = s + 1 + R;
      s_ready[r] = 1;
      for (int c = s; c <= r; c++) e_busy[c] = 1;
      for (int c = s + 1; c <= r; c++) e_en[c] = 1;
      for (int c = r + 1; c < MAXC; c++) e_idx[c] = k + 1;
      if (k == L - 1) begin
        e_done[r + 1] = 1;
        e_busy[r + 1] = 1;
      end else begin
        for (int c = r + 1; c <= r + G; c++) e_busy[c] = 1;
        s = r + 1 + G;
      end
    end
    if (abort_at >= 0) begin
      s_abort[abort_at] = 1;
      for (int c = abort_at + 1; c < MAXC; c++) begin
        e_arm[c] = 0; e_en[c] = 0; e_busy[c] = 0; e_done[c] = 0;
        e_idx[c] = e_idx[abort_at]; e_tmo[c] = e_tmo[abort_at];
        s_ready[c] = 0;
      end
    end
    if (extra_start >= 0) s_start[extra_start] = 1;
  endtask

  // Called just after a rising edge; length/gap are scrambled after cycle 0.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      cyc          = c;
      i_Start      = s_start[c][0];
      i_Abort      = s_abort[c][0];
      i_Gen_Ready  = s_ready[c][0];
      i_Burst_Len  = (c == 0) ? cfg_len : 8'hA5;
      i_Gap_Cycles = (c == 0) ? cfg_gap : 16'h0003;
      chk_en       = 1'b1;
      @(posedge i_Clk);
      #1;
    end
    chk_en = 1'b0;
    i_Start = 1'b0; i_Abort = 1'b0; i_Gen_Ready = 1'b0;
  endtask

  task automatic scen(input int L, input int G, input int R, input int abort_at,
                      input bit no_ready, input bit blocked, input int extra_start,
                      input int n);
    build(L, G, R, abort_at, no_ready, blocked, extra_start);
    stb_q.delete();
    done_at = -1; tmo_at = -1; arm_cnt = 0; en_cnt = 0;
    cfg_len = CW'(L);
    cfg_gap = GW'(G);
    run(n);
    idx_carry = e_idx[n - 1];
    tmo_carry = e_tmo[n - 1];
  endtask

  always @(negedge i_Clk) begin
    if (chk_en) begin
      chk("gen_arm",     int'(o_Gen_Arm),      e_arm[cyc]);
      chk("pulse_strobe", int'(o_Pulse_Strobe), e_arm[cyc]);
      chk("gen_enable",  int'(o_Gen_Enable),   e_en[cyc]);
      chk("busy",        int'(o_Busy),         e_busy[cyc]);
      chk("done",        int'(o_Done),         e_done[cyc]);
      chk("timeout",     int'(o_Timeout),      e_tmo[cyc]);
      chk("pulse_idx",   int'(o_Pulse_Idx),    e_idx[cyc]);
      if (o_Pulse_Strobe) stb_q.push_back(cyc);
      if (o_Gen_Arm) arm_cnt++;
      if (o_Gen_Enable) en_cnt++;
      if (o_Done && done_at < 0) done_at = cyc;
      if (o_Timeout && tmo_at < 0) tmo_at = cyc;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_arm"},  int'(o_Gen_Arm),      0);
    chk({tag, "_stb"},  int'(o_Pulse_Strobe), 0);
    chk({tag, "_en"},   int'(o_Gen_Enable),   0);
    chk({tag, "_busy"}, int'(o_Busy),         0);
    chk({tag, "_done"}, int'(o_Done),         0);
    chk({tag, "_tmo"},  int'(o_Timeout),      0);
    chk({tag, "_idx"},  int'(o_Pulse_Idx),    0);
  endtask

  initial begin
    #1 i_Rst_L = 1'b0;
    #3 chk_all_zero("reset");
    #31 i_Rst_L = 1'b1;
    @(posedge i_Clk);
    #1;

    // len=3 gap=4, ready 5 cycles after enable; a start while busy is ignored
    scen(3, 4, 5, -1, 1'b0, 1'b0, 5, 40);
    chk("s1_strobes", stb_q.size(), 3);
    if (stb_q.size() == 3) begin
      chk("s1_stb0", stb_q[0], 1);
      chk("s1_stb1", stb_q[1], 12);
      chk("s1_stb2", stb_q[2], 23);
    end
    chk("s1_done_at", done_at, 30);

    // len=0: immediate done, generator untouched
    scen(0, 4, 0, -1, 1'b0, 1'b0, -1, 6);
    chk("s2_done_at", done_at, 1);
    chk("s2_arms", arm_cnt, 0);
    chk("s2_enables", en_cnt, 0);

    // len=2 gap=0: back-to-back re-arm right after ready
    scen(2, 0, 3, -1, 1'b0, 1'b0, -1, 20);
    chk("s3_strobes", stb_q.size(), 2);
    if (stb_q.size() == 2) chk("s3_stb1", stb_q[1], 6);
    chk("s3_done_at", done_at, 11);

    // generator never answers: watchdog expiry
    scen(2, 3, 0, -1, 1'b1, 1'b0, -1, 262);
    chk("s4_tmo_at", tmo_at, 257);
    chk("s4_done_at", done_at, -1);
    chk("s4_enables", en_cnt, 255);

    // next accepted start clears the sticky timeout
    scen(1, 0, 0, -1, 1'b0, 1'b0, -1, 8);
    chk("s5_done_at", done_at, 3);

    // start and abort together in IDLE: nothing happens
    scen(2, 2, 1, -1, 1'b0, 1'b1, -1, 5);
    chk("s6_arms", arm_cnt, 0);

    // abort during the gap of a len=5 burst
    scen(5, 6, 2, 7, 1'b0, 1'b0, -1, 14);
    chk("s7_done_at", done_at, -1);
    chk("s7_idx", int'(o_Pulse_Idx), 1);

    // abort coincident with ready: that pulse is not counted
    scen(3, 2, 2, 10, 1'b0, 1'b0, -1, 16);
    chk("s8_done_at", done_at, -1);
    chk("s8_idx", int'(o_Pulse_Idx), 1);

    // asynchronous reset between edges while in FIRE
    i_Burst_Len = 8'd4; i_Gap_Cycles = 16'd2; i_Start = 1'b1;
    @(posedge i_Clk); #1 i_Start = 1'b0;
    @(posedge i_Clk); #1;
    @(posedge i_Clk); #3;
    chk("pre_reset_en", int'(o_Gen_Enable), 1);
    i_Rst_L = 1'b0;
    #1 chk_all_zero("midrst");
    #4 i_Rst_L = 1'b1;
    @(posedge i_Clk); #1;
    idx_carry = 0;
    tmo_carry = 0;

    // normal burst after reset, with a start during the gap that must be ignored
    scen(2, 1, 1, -1, 1'b0, 1'b0, 4, 15);
    chk("s10_done_at", done_at, 8);
    chk("s10_strobes", stb_q.size(), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench time limit");
  end

endmodule
